// File: rtl/pipeline_control.sv
// Pipeline sequencing for the five-stage LC-3b core: load enables, stage valid bits, fetch redirect.
// Optional stall performance counters are built when PIPECTRL_PERF_EN is defined.
module pipeline_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dep_stall,
    input  logic        icache_resp,
    input  logic        dcache_req,
    input  logic        dcache_resp,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        ld_pc,
    output logic        ld_if_de,
    output logic        ld_de_ex,
    output logic        ld_ex_mem,
    output logic        ld_mem_wb,
    output logic        pcmux_sel,
    output logic [15:0] redirect_pc,
    output logic        v_de,
    output logic        v_ex,
    output logic        v_mem,
    output logic        v_wb,
    output logic [31:0] stall_dep_cnt,
    output logic [31:0] stall_mem_cnt
);

    typedef enum logic {RUN, PEND} state_t;

    state_t      state, state_nx;
    logic [15:0] tgt_q, tgt_nx;
    logic        v_de_nx, v_ex_nx, v_mem_nx, v_wb_nx;
    logic        mem_stall, flush, hz, hz_run;

    assign mem_stall = v_mem & dcache_req & ~dcache_resp;
    assign flush     = v_mem & br_taken;
    assign hz        = v_de & dep_stall;

    // Priority: D-cache stall, branch flush, decode hazard, normal advance.
    always_comb begin
        state_nx    = state;
        tgt_nx      = tgt_q;
        v_de_nx     = v_de;
        v_ex_nx     = v_ex;
        v_mem_nx    = v_mem;
        v_wb_nx     = v_wb;
        ld_pc       = 1'b0;
        ld_if_de    = 1'b0;
        ld_de_ex    = 1'b0;
        ld_ex_mem   = 1'b0;
        ld_mem_wb   = 1'b0;
        pcmux_sel   = 1'b0;
        redirect_pc = br_target;
        hz_run      = 1'b0;

        if (state == PEND) begin
            pcmux_sel   = 1'b1;
            redirect_pc = tgt_q;
        end

        if (mem_stall) begin
            ld_mem_wb = 1'b1;
            v_wb_nx   = 1'b0;
        end else if (flush) begin
            ld_if_de  = 1'b1;
            ld_de_ex  = 1'b1;
            ld_ex_mem = 1'b1;
            ld_mem_wb = 1'b1;
            v_wb_nx   = 1'b1;
            v_mem_nx  = 1'b0;
            v_ex_nx   = 1'b0;
            v_de_nx   = 1'b0;
            if (icache_resp) begin
                ld_pc       = 1'b1;
                pcmux_sel   = 1'b1;
                redirect_pc = br_target;
                state_nx    = RUN;
            end else begin
                tgt_nx   = br_target;
                state_nx = PEND;
            end
        end else if (hz) begin
            ld_de_ex  = 1'b1;
            ld_ex_mem = 1'b1;
            ld_mem_wb = 1'b1;
            v_ex_nx   = 1'b0;
            v_mem_nx  = v_ex;
            v_wb_nx   = v_mem;
            hz_run    = (state == RUN);
        end else begin
            ld_pc     = icache_resp;
            ld_if_de  = 1'b1;
            ld_de_ex  = 1'b1;
            ld_ex_mem = 1'b1;
            ld_mem_wb = 1'b1;
            // In PEND the fetch that completes belongs to the squashed path.
            v_de_nx   = icache_resp & (state == RUN);
            v_ex_nx   = v_de;
            v_mem_nx  = v_ex;
            v_wb_nx   = v_mem;
            if (state == PEND && icache_resp)
                state_nx = RUN;
        end

        if (!rst_n) begin
            ld_pc       = 1'b0;
            ld_if_de    = 1'b0;
            ld_de_ex    = 1'b0;
            ld_ex_mem   = 1'b0;
            ld_mem_wb   = 1'b0;
            pcmux_sel   = 1'b0;
            redirect_pc = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            tgt_q <= 16'h0000;
            v_de  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else begin
            state <= state_nx;
            tgt_q <= tgt_nx;
            v_de  <= v_de_nx;
            v_ex  <= v_ex_nx;
            v_mem <= v_mem_nx;
            v_wb  <= v_wb_nx;
        end
    end

`ifdef PIPECTRL_PERF_EN
    logic [31:0] dep_cnt_q, mem_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dep_cnt_q <= 32'd0;
            mem_cnt_q <= 32'd0;
        end else begin
            if (hz_run && !mem_stall && !flush)
                dep_cnt_q <= dep_cnt_q + 32'd1;
            if (mem_stall)
                mem_cnt_q <= mem_cnt_q + 32'd1;
        end
    end

    assign stall_dep_cnt = dep_cnt_q;
    assign stall_mem_cnt = mem_cnt_q;
`else
    logic unused_hz_run;
    assign unused_hz_run = hz_run;
    assign stall_dep_cnt = 32'd0;
    assign stall_mem_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: a stage-occupancy model checked every cycle plus literal spot checks.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        rst_n, dep_stall, icache_resp, dcache_req, dcache_resp, br_taken;
    logic [15:0] br_target;
    logic        ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb, pcmux_sel;
    logic [15:0] redirect_pc;
    logic        v_de, v_ex, v_mem, v_wb;
    logic [31:0] stall_dep_cnt, stall_mem_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_control dut (
        .clk(clk), .rst_n(rst_n), .dep_stall(dep_stall), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp), .br_taken(br_taken),
        .br_target(br_target), .ld_pc(ld_pc), .ld_if_de(ld_if_de), .ld_de_ex(ld_de_ex),
        .ld_ex_mem(ld_ex_mem), .ld_mem_wb(ld_mem_wb), .pcmux_sel(pcmux_sel),
        .redirect_pc(redirect_pc), .v_de(v_de), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
        .stall_dep_cnt(stall_dep_cnt), .stall_mem_cnt(stall_mem_cnt)
    );

    always #5 clk = ~clk;

    // Model: occupancy of DE, EX, MEM, WB (index 0..3), pending redirect, counters.
    bit          mv [4];
    bit          m_pend;
    logic [15:0] m_tgt;
    logic [31:0] m_dep, m_mem;
    bit          started = 1'b0;

    // 0 reset, 1 dcache stall, 2 flush, 3 decode hazard, 4 advance
    function automatic int classify();
        if (!rst_n)                                return 0;
        if (mv[2] && dcache_req && !dcache_resp)   return 1;
        if (mv[2] && br_taken)                     return 2;
        if (mv[0] && dep_stall)                    return 3;
        return 4;
    endfunction

    // Registers from boundary k onward load; boundary 0 is the PC.
    function automatic int first_loaded(int act);
        case (act)
            1:       return 4;
            3:       return 2;
            2, 4:    return 1;
            default: return 5;
        endcase
    endfunction

    always @(posedge clk) begin
        automatic int act = classify();
        automatic int k;
        automatic bit ins;
        if (act == 0) begin
            foreach (mv[i]) mv[i] = 1'b0;
            m_pend = 1'b0; m_tgt = 16'h0; m_dep = 0; m_mem = 0;
            started = 1'b1;
        end else if (act == 2) begin
            mv[3] = mv[2]; mv[2] = 1'b0; mv[1] = 1'b0; mv[0] = 1'b0;
            if (!icache_resp) begin m_pend = 1'b1; m_tgt = br_target; end
            else m_pend = 1'b0;
        end else begin
            k   = (act == 1) ? 3 : (act == 3) ? 1 : 0;
            ins = (act == 4) ? (icache_resp && !m_pend) : 1'b0;
            for (int i = 3; i > k; i--) mv[i] = mv[i-1];
            mv[k] = ins;
            if (act == 1) m_mem = m_mem + 1;
            if (act == 3 && !m_pend) m_dep = m_dep + 1;
            if (act == 4 && icache_resp) m_pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        automatic int act, k;
        automatic logic [4:0]  e_ld;
        automatic logic        e_sel;
        automatic logic [15:0] e_red;
        automatic logic [25:0] exp_v, act_v;
        automatic logic [31:0] e_dep, e_mem;
        if (started) begin
            act = classify();
            k   = first_loaded(act);
            for (int i = 1; i <= 4; i++) e_ld[4-i] = (i >= k);
            e_ld[4] = (k == 1) && icache_resp;
            if (act == 0)                          begin e_sel = 1'b0; e_red = br_target; end
            else if (act == 2 && icache_resp)      begin e_sel = 1'b1; e_red = br_target; end
            else                                   begin e_sel = m_pend; e_red = m_pend ? m_tgt : br_target; end
            exp_v = {e_ld, e_sel, e_red, mv[0], mv[1], mv[2], mv[3]};
            act_v = {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb, pcmux_sel, redirect_pc,
                     v_de, v_ex, v_mem, v_wb};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL cycle_outputs t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
`ifdef PIPECTRL_PERF_EN
            e_dep = m_dep; e_mem = m_mem;
`else
            e_dep = 32'd0; e_mem = 32'd0;
`endif
            n_cmp++;
            if (stall_dep_cnt !== e_dep || stall_mem_cnt !== e_mem) begin
                n_fail++;
                $display("[TB] FAIL cycle_counters t=%0t got=%0d/%0d want=%0d/%0d",
                         $time, stall_dep_cnt, stall_mem_cnt, e_dep, e_mem);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic dep, input logic ic,
                                 input logic dreq, input logic dresp, input logic br,
                                 input logic [15:0] tgt);
        rst_n = rst; dep_stall = dep; icache_resp = ic;
        dcache_req = dreq; dcache_resp = dresp; br_taken = br; br_target = tgt;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        applyStimulus(0, 0, 1, 0, 0, 0, 16'h0000);
        checkOutput("reset_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b00000);
        checkOutput("reset_sel", pcmux_sel, 1'b0);
        tick(2);
        checkOutput("reset_valid", {v_de, v_ex, v_mem, v_wb}, 4'b0000);

        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0000);
        checkOutput("fill_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b11111);
        tick(1);
        checkOutput("fill_c1", {v_de, v_ex, v_mem, v_wb}, 4'b1000);
        tick(3);
        checkOutput("fill_c4", {v_de, v_ex, v_mem, v_wb}, 4'b1111);

        applyStimulus(1, 1, 1, 0, 0, 0, 16'h0000);
        checkOutput("hz_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b00111);
        tick(1);
        checkOutput("hz_c1", {v_de, v_ex, v_mem, v_wb}, 4'b1011);
        tick(1);
        checkOutput("hz_c2", {v_de, v_ex, v_mem, v_wb}, 4'b1001);
        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0000);
        tick(3);
        checkOutput("hz_refill", {v_de, v_ex, v_mem, v_wb}, 4'b1111);
`ifdef PIPECTRL_PERF_EN
        checkOutput("dep_cnt", stall_dep_cnt, 32'd2);
`endif

        applyStimulus(1, 0, 1, 1, 0, 0, 16'h0000);
        checkOutput("mem_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b00001);
        tick(3);
        checkOutput("mem_valid", {v_de, v_ex, v_mem, v_wb}, 4'b1110);
        applyStimulus(1, 0, 1, 1, 1, 0, 16'h0000);
        checkOutput("mem_done_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b11111);
        tick(1);
        checkOutput("mem_after", {v_de, v_ex, v_mem, v_wb}, 4'b1111);
`ifdef PIPECTRL_PERF_EN
        checkOutput("mem_cnt", stall_mem_cnt, 32'd3);
`endif

        applyStimulus(1, 0, 1, 0, 0, 1, 16'h3000);
        checkOutput("br_hit_sel", pcmux_sel, 1'b1);
        checkOutput("br_hit_pc", redirect_pc, 16'h3000);
        checkOutput("br_hit_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b11111);
        tick(1);
        checkOutput("br_hit_valid", {v_de, v_ex, v_mem, v_wb}, 4'b0001);

        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0000);
        tick(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 16'h1234);
        checkOutput("br_miss_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b01111);
        checkOutput("br_miss_sel", pcmux_sel, 1'b0);
        tick(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 16'hBEEF);
        checkOutput("pend_pc", redirect_pc, 16'h1234);
        checkOutput("pend_sel", pcmux_sel, 1'b1);
        checkOutput("pend_ldpc", ld_pc, 1'b0);
        tick(2);
        applyStimulus(1, 0, 1, 0, 0, 0, 16'hBEEF);
        checkOutput("pend_resp_ldpc", ld_pc, 1'b1);
        checkOutput("pend_resp_pc", redirect_pc, 16'h1234);
        tick(1);
        checkOutput("pend_drop", v_de, 1'b0);
        checkOutput("pend_back_sel", pcmux_sel, 1'b0);

        tick(3);
        applyStimulus(1, 0, 0, 0, 0, 1, 16'h5555);
        tick(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000);
        checkOutput("rst_pend_ld", {ld_pc, ld_if_de, ld_de_ex, ld_ex_mem, ld_mem_wb}, 5'b00000);
        checkOutput("rst_pend_sel", pcmux_sel, 1'b0);
        tick(2);
        checkOutput("rst_pend_valid", {v_de, v_ex, v_mem, v_wb}, 4'b0000);
        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0000);
        checkOutput("rst_pend_run", pcmux_sel, 1'b0);
        checkOutput("rst_cnt", stall_dep_cnt | stall_mem_cnt, 32'd0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Pipeline sequencing block for the five-stage LC-3b core (IF, DE, EX, MEM, WB). It consumes the decode-stage `dep_stall` from the dependency logic, the I-cache and D-cache handshakes and the MEM-stage branch resolution. From these it drives the load enables of the PC and every inter-stage register, owns the per-stage valid bits (including the `v_*` qualifiers the dependency logic relies on), and redirects fetch on taken branches. It sits between the hazard-detection logic and the datapath pipeline registers.

## Interface
Parameters:
- none (word width fixed at 16, `lc3b_word`)

Ports:
- `clk` in 1: core clock; all state updates on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `dep_stall` in 1: RAW/CC hazard on the instruction in DE, from dependency logic
- `icache_resp` in 1: I-cache has returned the fetch for the current PC this cycle
- `dcache_req` in 1: instruction in MEM is accessing the D-cache
- `dcache_resp` in 1: D-cache access completes this cycle
- `br_taken` in 1: instruction in MEM is a taken control transfer
- `br_target` in 16: redirect address for `br_taken`
- `ld_pc`, `ld_if_de`, `ld_de_ex`, `ld_ex_mem`, `ld_mem_wb` out 1 each: pipeline register load enables
- `pcmux_sel` out 1: 1 = PC loads `redirect_pc`, 0 = sequential PC+2
- `redirect_pc` out 16: redirect address
- `v_de`, `v_ex`, `v_mem`, `v_wb` out 1 each: registered stage valid bits
- `stall_dep_cnt`, `stall_mem_cnt` out 32 each: performance counters (see Configuration)

## Operation
- Derived terms:
  - `mem_stall = v_mem & dcache_req & ~dcache_resp`
  - `flush = v_mem & br_taken`
  - `hz = v_de & dep_stall`
- Unqualified `dep_stall` while `v_de=0` is ignored.
- FSM has two states: RUN and PEND. PEND means a redirect is waiting for an outstanding I-cache fetch to finish.
- A saved 16-bit target register `tgt_q` holds the redirect address while in PEND.

Priority in RUN, first match wins:
1. `mem_stall`:
   - `ld_mem_wb=1`; all other `ld_*=0`
   - `v_wb<=0`; `v_de`, `v_ex`, `v_mem` hold
2. `flush`:
   - `ld_if_de=ld_de_ex=ld_ex_mem=ld_mem_wb=1`
   - `v_wb<=1`; `v_mem<=0`, `v_ex<=0`, `v_de<=0`
   - If `icache_resp=1`: `ld_pc=1`, `pcmux_sel=1`, `redirect_pc=br_target`; stay in RUN.
   - Else: `ld_pc=0`, `tgt_q<=br_target`, go to PEND.
3. `hz`:
   - `ld_pc=0`, `ld_if_de=0`, `ld_de_ex=ld_ex_mem=ld_mem_wb=1`
   - `v_ex<=0` (bubble); `v_de` holds; `v_mem<=v_ex`; `v_wb<=v_mem`
4. Otherwise:
   - all `ld_*=1` except `ld_pc=icache_resp`
   - `v_de<=icache_resp`; `v_ex<=v_de`; `v_mem<=v_ex`; `v_wb<=v_mem`

In PEND:
- `pcmux_sel=1`, `redirect_pc=tgt_q`; downstream advances as in case 4.
- While `icache_resp=0`: `v_de<=0`.
- When `icache_resp=1`: `ld_pc=1`, `v_de<=0` (the stale fetch is dropped), go to RUN.
- `mem_stall`, `flush` and `hz` cannot arise in PEND because the flush cleared EX/MEM/DE. They are still evaluated with the priority above, but with `ld_pc` forced to 0 until `icache_resp`.

Default and reset values:
- `redirect_pc=br_target` and `pcmux_sel=0` whenever no redirect is active.
- Reset (`rst_n=0` at a rising edge): all `v_*`=0, state RUN, `tgt_q`=0, counters 0.
- While `rst_n=0`, every `ld_*`=0 and `pcmux_sel=0`.
- Reset asserted in PEND abandons the redirect.

## Timing
- `ld_*`, `pcmux_sel` and `redirect_pc` are combinational from the inputs and current state, valid in the same cycle.
- `v_*`, state and `tgt_q` are registered and change only on the rising edge.
- Branch penalty:
  - Redirected PC is loaded at the edge ending the `flush` cycle; the first target fetch is in the following cycle.
  - The 3 younger instructions are squashed.
  - If the I-cache is busy, the penalty extends by the remaining miss cycles, plus one dropped fetch.
- A `dep_stall` bubble costs exactly one cycle per asserted cycle.
- A D-cache miss of N cycles holds IF..MEM for N cycles and sends N bubbles into WB.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.

## Configuration
- `PIPECTRL_PERF_EN`:
  - Defined: `stall_dep_cnt` increments on every RUN cycle whose action is case 3 (`hz`); `stall_mem_cnt` increments on every cycle with `mem_stall`. Both are cleared by reset.
  - Undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset then `icache_resp=1` constant, no hazards -> `v_de`..`v_wb` fill 1 per cycle; `v_wb=1` by cycle 4; all `ld_*=1`.
- `v_de=1`, `dep_stall=1` for 2 cycles -> `ld_pc=ld_if_de=0` for 2 cycles; two bubbles appear in EX (`v_ex=0`), then reach MEM and WB; with PERF, `stall_dep_cnt=2`.
- `v_mem=1`, `dcache_req=1`, `dcache_resp` high on the 4th cycle -> IF..MEM frozen 3 cycles; `v_wb=0` for 3 cycles; with PERF, `stall_mem_cnt=3`.
- `flush` with `br_target=0x3000`, `icache_resp=1` -> `pcmux_sel=1`, `redirect_pc=0x3000`, `ld_pc=1`; next cycle `v_de=v_ex=v_mem=0`, `v_wb=1`.
- `flush` with `br_target=0x1234`, `icache_resp=0` for 2 more cycles -> PEND; `redirect_pc=0x1234`, `ld_pc=0` until `icache_resp`; then `ld_pc=1`, `v_de` stays 0, state RUN.
- `rst_n=0` asserted in PEND -> next cycle state RUN, all `v_*=0`, counters 0, `ld_*=0` while reset is held.
